mem_tile_loader: RTL

MEM_TILE_LOADER -- requirements
Module: mem_tile_loader

---
 rtl/conv_pkg.sv | 17 +
 rtl/loader_skid_fifo.sv | 58 +++++
 rtl/mem_tile_loader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the tile loader: FSM state encoding and default
// geometry (address/data width, external read latency, skid buffer depth).
package conv_pkg;

  localparam int CONV_AW         = 16;
  localparam int CONV_DW         = 32;
  localparam int CONV_RD_LAT     = 2;
  localparam int CONV_SKID_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/loader_skid_fifo.sv
// Small skid buffer that catches read data returning from memory.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   wr_en, wr_data  write side; the caller guarantees the buffer is not full
//   rd_en           pop the head; the caller guarantees the buffer is not empty
//   rd_data         current head word (valid whenever count != 0)
//   count           current occupancy, 0..DEPTH
module loader_skid_fifo
  import conv_pkg::*;
#(
  parameter int DW    = CONV_DW,
  parameter int DEPTH = CONV_SKID_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DW-1:0]              wr_data,
  input  logic                       rd_en,
  output logic [DW-1:0]              rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q + PW'(rd_en);
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the occupancy count decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/mem_tile_loader.sv
// Streams a tile of len words starting at base_addr from a fixed-latency
// memory into a downstream FIFO, with credit-based flow control so returning
// data always has a skid slot.
// Ports:
//   clk, rst                   clock, synchronous active-low reset
//   start, base_addr, len      tile request (sampled only in IDLE)
//   rd_en, rd_addr, rd_data    external memory read port, RD_LAT cycles latency
//   fifo_almost_full           downstream backpressure
//   fifo_push, fifo_data       downstream push port
//   busy, done                 status: busy for the whole tile, done one-cycle pulse
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_RUN   | issuing reads (and pushing whatever has returned)
// ST_DRAIN | all reads issued, pushing the remaining words
// ST_FIN   | one-cycle wrap-up before returning to IDLE
module mem_tile_loader
  import conv_pkg::*;
#(
  parameter int AW         = CONV_AW,
  parameter int DW         = CONV_DW,
  parameter int RD_LAT     = CONV_RD_LAT,
  parameter int SKID_DEPTH = CONV_SKID_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] len,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  input  logic          fifo_almost_full,
  output logic          fifo_push,
  output logic [DW-1:0] fifo_data,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int OW = $clog2(SKID_DEPTH + RD_LAT + 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     base_q, base_d;
  logic [AW-1:0]     len_q, len_d;
  logic [AW:0]       issue_cnt_q, issue_cnt_d;
  logic [AW:0]       push_cnt_q, push_cnt_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CW-1:0]     skid_cnt;
  logic [DW-1:0]     skid_head;
  logic [OW-1:0]     inflight;
  logic              issue;
  logic              push;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + OW'(vld_q[i]);
  end

  // A read only goes out if a skid slot is reserved for its data.
  assign issue = (state_q == ST_RUN) && (issue_cnt_q < {1'b0, len_q}) &&
                 ((OW'(skid_cnt) + inflight) < OW'(SKID_DEPTH));
  assign push  = (skid_cnt != '0) && !fifo_almost_full;

  loader_skid_fifo #(
    .DW    (DW),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (vld_q[RD_LAT-1]),
    .wr_data (rd_data),
    .rd_en   (push),
    .rd_data (skid_head),
    .count   (skid_cnt)
  );

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q + {{AW{1'b0}}, issue};
    push_cnt_d  = push_cnt_q + {{AW{1'b0}}, push};
    vld_d       = (vld_q << 1) | RD_LAT'(issue);
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d      = base_addr;
          len_d       = len;
          issue_cnt_d = '0;
          push_cnt_d  = '0;
          busy_d      = 1'b1;
          state_d     = (len == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue_cnt_d == {1'b0, len_q}) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Signal completion right after the last push.
        if (push_cnt_d == {1'b0, len_q}) begin
          state_d = ST_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_FIN: begin
        // Arriving here with busy still set means an empty tile: its done
        // pulse is issued on the way out instead.
        state_d = ST_IDLE;
        done_d  = busy_q;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      push_cnt_q  <= '0;
      vld_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      push_cnt_q  <= push_cnt_d;
      vld_q       <= vld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_en     = issue;
  assign rd_addr   = issue ? (base_q + issue_cnt_q[AW-1:0]) : '0;
  assign fifo_push = push;
  assign fifo_data = push ? skid_head : '0;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
